agc_timepulse_gen: RTL
======================

AGC_TIMEPULSE_GEN -- requirements
Module: agc_timepulse_gen

Interface
REQ-001 SHALL provide parameter DIV, default 2: SIM_CLK cycles per clock phase, legal range 1..256.
REQ-002 SHALL provide parameter NT, default 12: number of time pulses per memory cycle (MCT), legal range 2..15.
REQ-003 SHALL provide parameter TW, default 4: width of TNUM; must satisfy 2^TW > NT.
REQ-004 SIM_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SIM_RST  in  1  reset, synchronous, active-high.
REQ-006 GOJ1, STRT1, STRT2  in  1 each  restart requests, ORed together.
REQ-007 SBY  in  1  standby; freezes timing while high.
REQ-008 MSTP  in  1  monitor stop request.
REQ-009 MSTRTP  in  1  monitor step request; acts on its rising edge.
REQ-010 WL_OVF  in  2  {WL16, WL15} sign and overflow bits of the write bus.
REQ-011 PHS  out  4  one-hot clock phase, PHS[0] = phase 1.
REQ-012 RT, WT, CT  out  1 each  read, write and clear strobes.
REQ-013 T  out  NT  one-hot time pulse, T[0] = T01.
REQ-014 TNUM  out  TW  current time-pulse number, 1..NT.
REQ-015 GOJAM, STOP, TIMR, OVF_n, UNF_n  out  1 each  restart active, halted, MCT tick, overflow (low-true), underflow (low-true).

Function
REQ-016 Divider div_cnt SHALL count 0..DIV-1; a "phase tick" is a cycle with div_cnt == DIV-1 while running and SBY is low.
REQ-017 Each phase tick SHALL advance the phase 1->2->3->4->1; outputs SHALL be RT = phase 1, WT = phase 2, CT = phase 4, all decoded from registered state.
REQ-018 A phase tick in phase 4 is a "pulse end"; TNUM SHALL advance n->n+1 and wrap NT->1. T SHALL be the one-hot decode of TNUM.
REQ-019 TIMR SHALL be 1 for exactly the one SIM_CLK cycle following a pulse end at TNUM == NT, and 0 otherwise.
REQ-020 Restart requests SHALL set a pending flag on any cycle. At the next pulse end with pending set: TNUM forced to NT, GOJAM = 1 for that entire pulse, pending cleared. At the end of that pulse GOJAM = 0 and TNUM = 1.
REQ-021 A request arriving during a GOJAM pulse SHALL re-set pending, which extends GOJAM by one more NT pulse.
REQ-022 The state machine SHALL have two states, RUN and HALT. Transition RUN->HALT occurs at a pulse end at TNUM == NT when MSTP = 1 and no restart is pending.
REQ-023 In HALT: TNUM holds NT, div_cnt and phase are frozen, PHS = 0, RT = WT = CT = 0, STOP = 1.
REQ-024 HALT->RUN SHALL occur on MSTP = 0, on a registered MSTRTP rising edge, or on a pending restart. On resume: TNUM = 1, phase 1, div_cnt = 0, STOP = 0.
REQ-025 A step resume SHALL run exactly one MCT (T01..T(NT)), then re-enter HALT if MSTP is still 1.
REQ-026 A restart from HALT SHALL resume directly into the GOJAM pulse at TNUM = NT, phase 1.
REQ-027 While SBY = 1, all state and outputs SHALL be frozen (no phase ticks, TIMR = 0). Pending-flag and MSTRTP edge capture SHALL still operate.
REQ-028 Overflow strobe: on every pulse end, WL_OVF SHALL be sampled. 2'b01 -> OVF_n = 0, UNF_n = 1; 2'b10 -> UNF_n = 0, OVF_n = 1; 2'b00 or 2'b11 -> both 1. The result is held until the next strobe; no strobe occurs in HALT.

Reset
REQ-029 SIM_RST SHALL have priority over all inputs, including SBY.
REQ-030 On reset: div_cnt = 0, phase 1 (PHS = 4'b0001, RT = 1, WT = CT = 0), TNUM = NT, T = one-hot T(NT), state RUN, GOJAM = 1, pending = 0, STOP = 0, TIMR = 0, OVF_n = UNF_n = 1, MSTRTP edge register = 0.
REQ-031 Reset asserted mid-operation SHALL produce the reset values on the cycle after the reset edge, regardless of state.

Verification (DIV = 2, NT = 12)
REQ-032 Reset release, idle inputs -> GOJAM = 1 with TNUM = 12 for 8 clocks, then T01 for 8 clocks; TIMR pulses every 96 clocks; RT, WT and CT each high for 2 clocks per pulse.
REQ-033 GOJ1 one-cycle pulse during T05 phase 2 -> T05 completes, then TNUM = 12 with GOJAM = 1 for 8 clocks, then T01 with GOJAM = 0.
REQ-034 MSTP = 1 -> HALT after the T12 pulse end with STOP = 1 and PHS = 0. An MSTRTP pulse then gives exactly 96 clocks of T01..T12 and HALT again. MSTP = 0 -> resume at T01.
REQ-035 WL_OVF = 01 at a pulse end -> OVF_n = 0 from the next cycle until the next pulse end. WL_OVF = 10 -> UNF_n = 0. WL_OVF = 11 -> both 1.
REQ-036 SBY high for 20 clocks during T03 phase 2 -> all outputs constant; resumes with identical remaining phase timing. GOJ1 during SBY yields GOJAM at the first pulse end after SBY falls.
REQ-037 SIM_RST pulse during T07 phase 3 while a restart is pending -> next cycle all outputs equal the REQ-030 values, and the pending restart is discarded.

Source files
------------

// File: rtl/agc_timepulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : agc_timepulse_gen_if
// Brief    : Request/strobe bundle between the AGC timing generator and its
//            surroundings; "slave" is the generator side.
// Revision : 1.0
// ============================================================================
interface agc_timepulse_gen_if #(
    parameter int NT = 12,
    parameter int TW = 4
);
    logic          GOJ1;
    logic          STRT1;
    logic          STRT2;
    logic          SBY;
    logic          MSTP;
    logic          MSTRTP;
    logic [1:0]    WL_OVF;
    logic [3:0]    PHS;
    logic          RT;
    logic          WT;
    logic          CT;
    logic [NT-1:0] T;
    logic [TW-1:0] TNUM;
    logic          GOJAM;
    logic          STOP;
    logic          TIMR;
    logic          OVF_n;
    logic          UNF_n;

    modport master (
        output GOJ1, STRT1, STRT2, SBY, MSTP, MSTRTP, WL_OVF,
        input  PHS, RT, WT, CT, T, TNUM, GOJAM, STOP, TIMR, OVF_n, UNF_n
    );

    modport slave (
        input  GOJ1, STRT1, STRT2, SBY, MSTP, MSTRTP, WL_OVF,
        output PHS, RT, WT, CT, T, TNUM, GOJAM, STOP, TIMR, OVF_n, UNF_n
    );
endinterface
`default_nettype wire

// File: rtl/agc_timepulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : agc_timepulse_gen
// Brief    : AGC clock-phase / time-pulse sequencer with restart (GOJAM),
//            monitor stop/step, standby freeze and overflow strobe.
// Revision : 1.0
// ============================================================================
module agc_timepulse_gen #(
    parameter int DIV = 2,
    parameter int NT  = 12,
    parameter int TW  = 4
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    agc_timepulse_gen_if.slave bus
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] TN_LAST  = TW'(NT);
    localparam logic [TW-1:0] TN_FIRST = TW'(1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]    r_state;
    logic [DW-1:0] r_div;
    logic [1:0]    r_phase;
    logic [TW-1:0] r_tnum;
    logic          r_gojam;
    logic          r_pend;
    logic          r_timr;
    logic          r_ovf_n;
    logic          r_unf_n;
    logic          r_mstrtp_q;
    logic          r_step;

    logic          w_req;
    logic          w_run;
    logic          w_tick;
    logic          w_pulse_end;
    logic          w_step_edge;
    logic          w_wake;
    logic          w_consume;
    logic [3:0]    w_phs;
    logic [NT-1:0] w_t;

    assign w_req       = bus.GOJ1 | bus.STRT1 | bus.STRT2;
    assign w_run       = (r_state == ST_RUN) && !bus.SBY;
    assign w_tick      = w_run && (r_div == DIV_LAST);
    assign w_pulse_end = w_tick && (r_phase == 2'd3);
    assign w_step_edge = bus.MSTRTP && !r_mstrtp_q;
    // A step edge seen during standby is latched in r_step and acted on later.
    assign w_wake      = (r_state == ST_HALT) && !bus.SBY &&
                         (r_pend || !bus.MSTP || r_step || w_step_edge);
    assign w_consume   = r_pend && (w_pulse_end || w_wake);

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_state    <= ST_RUN;
            r_div      <= '0;
            r_phase    <= 2'd0;
            r_tnum     <= TN_LAST;
            r_gojam    <= 1'b1;
            r_pend     <= 1'b0;
            r_timr     <= 1'b0;
            r_ovf_n    <= 1'b1;
            r_unf_n    <= 1'b1;
            r_mstrtp_q <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_mstrtp_q <= bus.MSTRTP;
            r_pend     <= w_req | (r_pend & ~w_consume);
            r_timr     <= w_pulse_end && (r_tnum == TN_LAST);

            if (r_state == ST_HALT) begin
                if (w_wake) begin
                    r_step <= 1'b0;
                end else if (w_step_edge) begin
                    r_step <= 1'b1;
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (w_run) begin
                        r_div <= w_tick ? '0 : r_div + DW'(1);
                        if (w_tick) begin
                            r_phase <= r_phase + 2'd1;
                        end
                        if (w_pulse_end) begin
                            r_ovf_n <= (bus.WL_OVF != 2'b01);
                            r_unf_n <= (bus.WL_OVF != 2'b10);
                            if (r_pend) begin
                                r_tnum  <= TN_LAST;
                                r_gojam <= 1'b1;
                            end else if ((r_tnum == TN_LAST) && bus.MSTP) begin
                                r_state <= ST_HALT;
                                r_gojam <= 1'b0;
                            end else begin
                                r_tnum  <= (r_tnum == TN_LAST) ? TN_FIRST : r_tnum + TW'(1);
                                r_gojam <= 1'b0;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    if (w_wake) begin
                        r_state <= ST_RUN;
                        r_div   <= '0;
                        r_phase <= 2'd0;
                        // A pending restart resumes straight into the GOJAM pulse.
                        r_tnum  <= r_pend ? TN_LAST : TN_FIRST;
                        r_gojam <= r_pend;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_phs = '0;
        for (int i = 0; i < 4; i++) begin
            w_phs[i] = (r_state == ST_RUN) && (r_phase == 2'(i));
        end
        w_t = '0;
        for (int i = 0; i < NT; i++) begin
            w_t[i] = (r_tnum == TW'(i + 1));
        end
    end

    assign bus.PHS   = w_phs;
    assign bus.RT    = w_phs[0];
    assign bus.WT    = w_phs[1];
    assign bus.CT    = w_phs[3];
    assign bus.T     = w_t;
    assign bus.TNUM  = r_tnum;
    assign bus.GOJAM = r_gojam;
    assign bus.STOP  = (r_state == ST_HALT);
    assign bus.TIMR  = r_timr;
    assign bus.OVF_n = r_ovf_n;
    assign bus.UNF_n = r_unf_n;

endmodule
`default_nettype wire
